instruction_loader: RTL and testbench

Byte-stream program loader that writes the instruction memory from outside the core. It accepts a framed byte stream over a valid/ready handshake and packs each group of four bytes big-endian into one 32-bit instruction word. The first byte of a group becomes bits [31:24], which is the same packing the fetch path uses when it reads bytes back. It writes each packed word to consecutive word-aligned addresses starting at 0 and holds the CPU while loading.

---
 rtl/instruction_loader_pkg.sv | 54 +++++
 rtl/instruction_loader_word_packer.sv | 36 +++
 rtl/instruction_loader.sv | 170 +++++++++++++++++
 tb/tb_instruction_loader.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/instruction_loader_pkg.sv
// Shared loader types and the ISA width/state macros (mirrors the ISA.v definitions).
// Guarded so an existing ISA.v included earlier takes precedence.
`ifndef LEN_ADDRESS
`define LEN_ADDRESS 32
`endif
`ifndef LEN_INSTRUCTION
`define LEN_INSTRUCTION 32
`endif
`ifndef LEN_INSTRUCTION_MEM
`define LEN_INSTRUCTION_MEM 8
`endif
`ifndef SIZE_INSTRUCTION_MEM
`define SIZE_INSTRUCTION_MEM 1024
`endif
`ifndef LOADER_IDLE
`define LOADER_IDLE   3'd0
`define LOADER_LEN_HI 3'd1
`define LOADER_LEN_LO 3'd2
`define LOADER_DATA   3'd3
`define LOADER_CSUM   3'd4
`define LOADER_DONE   3'd5
`define LOADER_ERROR  3'd6
`endif

package instruction_loader_pkg;

    localparam int unsigned ADDR_W  = `LEN_ADDRESS;
    localparam int unsigned WORD_W  = `LEN_INSTRUCTION;
    localparam int unsigned BYTE_W  = `LEN_INSTRUCTION_MEM;
    localparam int unsigned LANES   = WORD_W / BYTE_W;
    localparam int unsigned LANE_W  = $clog2(LANES);
    localparam int unsigned LEN_W   = 2 * BYTE_W;

    typedef enum logic [2:0] {
        LD_IDLE   = `LOADER_IDLE,
        LD_LEN_HI = `LOADER_LEN_HI,
        LD_LEN_LO = `LOADER_LEN_LO,
        LD_DATA   = `LOADER_DATA,
        LD_CSUM   = `LOADER_CSUM,
        LD_DONE   = `LOADER_DONE,
        LD_ERROR  = `LOADER_ERROR
    } loader_state_t;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [WORD_W-1:0] data;
    } mem_wr_t;

    // States in which the loader owns the byte stream.
    function automatic logic is_loading(input loader_state_t s);
        return (s == LD_LEN_HI) || (s == LD_LEN_LO) || (s == LD_DATA) || (s == LD_CSUM);
    endfunction

endpackage

// File: rtl/instruction_loader_word_packer.sv
// Big-endian byte-to-word assembler: lane 0 lands in the most significant byte.
module word_packer
    import instruction_loader_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              byte_valid,
    input  logic [BYTE_W-1:0] byte_data,
    output logic              word_valid,
    output logic [WORD_W-1:0] word
);

    localparam int unsigned HEAD_W = WORD_W - BYTE_W;

    logic [LANE_W-1:0] lane;
    logic [HEAD_W-1:0] head;

    // The final byte completes the word combinationally so the top can register it in one step.
    assign word_valid = byte_valid && (lane == LANE_W'(LANES - 1));
    assign word       = {head, byte_data};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lane <= '0;
            head <= '0;
        end else if (clear) begin
            lane <= '0;
            head <= '0;
        end else if (byte_valid) begin
            lane <= lane + LANE_W'(1);
            head <= {head[HEAD_W-BYTE_W-1:0], byte_data};
        end
    end

endmodule

// File: rtl/instruction_loader.sv
// Framed byte-stream loader that writes instruction memory while holding the CPU.
// Optional trailing XOR checksum byte enabled by LOADER_CHECKSUM_EN.
module instruction_loader
    import instruction_loader_pkg::*;
#(
    parameter int unsigned MAX_WORDS = `SIZE_INSTRUCTION_MEM / 4
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        start,
    input  logic                        in_valid,
    input  logic [BYTE_W-1:0]           in_data,
    output logic                        in_ready,
    output logic                        mem_we,
    output logic [`LEN_ADDRESS-1:0]     mem_addr,
    output logic [`LEN_INSTRUCTION-1:0] mem_wdata,
    output logic                        cpu_hold,
    output logic                        done,
    output logic                        error
);

    localparam int unsigned IDX_W = $clog2(MAX_WORDS + 1);
    localparam int unsigned CMP_W = LEN_W + 1;

    loader_state_t     state;
    logic [BYTE_W-1:0] len_hi;
    logic [LEN_W-1:0]  n_words;
    logic [IDX_W-1:0]  index;
    mem_wr_t           wr;
`ifdef LOADER_CHECKSUM_EN
    logic [BYTE_W-1:0] csum;
`endif

    logic              accept;
    logic              pk_clear;
    logic              pk_valid;
    logic              word_valid;
    logic [WORD_W-1:0] word;
    logic [LEN_W-1:0]  len_now;
    logic              oversize;
    logic              last_word;

    assign in_ready  = is_loading(state);
    assign accept    = in_valid && in_ready;
    assign pk_clear  = start && !in_ready;
    assign pk_valid  = accept && (state == LD_DATA);
    assign len_now   = {len_hi, in_data};
    assign oversize  = CMP_W'(len_now) > CMP_W'(MAX_WORDS);
    assign last_word = (CMP_W'(index) + CMP_W'(1)) == CMP_W'(n_words);

    assign mem_addr  = wr.addr;
    assign mem_wdata = wr.data;

    word_packer u_packer (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear      (pk_clear),
        .byte_valid (pk_valid),
        .byte_data  (in_data),
        .word_valid (word_valid),
        .word       (word)
    );

    // Frame sequencer; cpu_hold stays high through the cycle carrying the last write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= LD_IDLE;
            len_hi   <= '0;
            n_words  <= '0;
            index    <= '0;
            wr       <= '0;
            mem_we   <= 1'b0;
            cpu_hold <= 1'b0;
            done     <= 1'b0;
            error    <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
            csum     <= '0;
`endif
        end else begin
            mem_we <= 1'b0;
            case (state)
                LD_IDLE, LD_DONE, LD_ERROR: begin
                    cpu_hold <= 1'b0;
                    if (start) begin
                        state    <= LD_LEN_HI;
                        done     <= 1'b0;
                        error    <= 1'b0;
                        index    <= '0;
                        cpu_hold <= 1'b1;
`ifdef LOADER_CHECKSUM_EN
                        csum     <= '0;
`endif
                    end
                end
                LD_LEN_HI: begin
                    if (accept) begin
                        len_hi <= in_data;
                        state  <= LD_LEN_LO;
`ifdef LOADER_CHECKSUM_EN
                        csum   <= csum ^ in_data;
`endif
                    end
                end
                LD_LEN_LO: begin
                    if (accept) begin
                        n_words <= len_now;
`ifdef LOADER_CHECKSUM_EN
                        csum    <= csum ^ in_data;
`endif
                        if (oversize) begin
                            state    <= LD_ERROR;
                            error    <= 1'b1;
                            cpu_hold <= 1'b0;
                        end else if (len_now == '0) begin
`ifdef LOADER_CHECKSUM_EN
                            state    <= LD_CSUM;
`else
                            state    <= LD_DONE;
                            done     <= 1'b1;
                            cpu_hold <= 1'b0;
`endif
                        end else begin
                            state <= LD_DATA;
                        end
                    end
                end
                LD_DATA: begin
                    if (accept) begin
`ifdef LOADER_CHECKSUM_EN
                        csum <= csum ^ in_data;
`endif
                        if (word_valid) begin
                            mem_we  <= 1'b1;
                            wr.addr <= ADDR_W'({index, 2'b00});
                            wr.data <= word;
                            index   <= index + IDX_W'(1);
                            if (last_word) begin
`ifdef LOADER_CHECKSUM_EN
                                state <= LD_CSUM;
`else
                                state <= LD_DONE;
                                done  <= 1'b1;
`endif
                            end
                        end
                    end
                end
`ifdef LOADER_CHECKSUM_EN
                LD_CSUM: begin
                    if (accept) begin
                        cpu_hold <= 1'b0;
                        if (in_data == csum) begin
                            state <= LD_DONE;
                            done  <= 1'b1;
                        end else begin
                            state <= LD_ERROR;
                            error <= 1'b1;
                        end
                    end
                end
`endif
                default: begin
                    state    <= LD_IDLE;
                    cpu_hold <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instruction_loader.sv
// Randomized bench for instruction_loader against a byte-position frame model.
module tb_instruction_loader;

    localparam int unsigned MAXW = 256;
`ifdef LOADER_CHECKSUM_EN
    localparam bit CSUM_ON = 1'b1;
`else
    localparam bit CSUM_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        in_valid = 1'b0;
    logic [7:0]  in_data = 8'h00;
    logic        in_ready;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        cpu_hold;
    logic        done;
    logic        error;

    always #5 clk = ~clk;

    instruction_loader #(.MAX_WORDS(MAXW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .cpu_hold  (cpu_hold),
        .done      (done),
        .error     (error)
    );

    int checks = 0;
    int errors = 0;

    // Frame model: progress tracked purely by count of accepted bytes.
    bit          m_busy, m_we, m_done, m_err;
    int          m_pos, m_n;
    logic [7:0]  m_hi, m_csum;
    logic [7:0]  m_lane [4];
    logic [31:0] m_addr, m_wdata;

    int          we_pulses;
    logic [31:0] wr_addr_q[$];
    logic [31:0] wr_data_q[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_busy = 0; m_we = 0; m_done = 0; m_err = 0;
        m_pos = 0; m_n = 0; m_hi = 0; m_csum = 0;
        m_addr = 0; m_wdata = 0;
    endtask

    task automatic model_edge(input logic v, input logic [7:0] d, input logic s);
        int k;
        m_we = 0;
        if (!m_busy) begin
            if (s) begin
                m_busy = 1; m_pos = 0; m_done = 0; m_err = 0; m_csum = 0;
            end
        end else if (v) begin
            if (m_pos == 0) begin
                m_hi = d;
                m_csum ^= d;
            end else if (m_pos == 1) begin
                m_n = int'(m_hi) * 256 + int'(d);
                m_csum ^= d;
                if (m_n > int'(MAXW)) begin
                    m_busy = 0; m_err = 1;
                end else if (m_n == 0 && !CSUM_ON) begin
                    m_busy = 0; m_done = 1;
                end
            end else if (m_pos < 2 + 4 * m_n) begin
                k = m_pos - 2;
                m_lane[k % 4] = d;
                m_csum ^= d;
                if (k % 4 == 3) begin
                    m_we = 1;
                    m_addr = 32'((k / 4) * 4);
                    m_wdata = {m_lane[0], m_lane[1], m_lane[2], m_lane[3]};
                    if (k == 4 * m_n - 1 && !CSUM_ON) begin
                        m_busy = 0; m_done = 1;
                    end
                end
            end else begin
                m_busy = 0;
                if (d == m_csum) m_done = 1;
                else m_err = 1;
            end
            m_pos++;
        end
    endtask

    task automatic compare_outputs();
        chk("in_ready", 32'(in_ready), 32'(m_busy));
        chk("mem_we", 32'(mem_we), 32'(m_we));
        chk("cpu_hold", 32'(cpu_hold), 32'(m_busy || m_we));
        chk("done", 32'(done), 32'(m_done));
        chk("error", 32'(error), 32'(m_err));
        chk("mem_addr", mem_addr, m_addr);
        chk("mem_wdata", mem_wdata, m_wdata);
        if (mem_we === 1'b1) begin
            we_pulses++;
            wr_addr_q.push_back(mem_addr);
            wr_data_q.push_back(mem_wdata);
        end
    endtask

    task automatic step(input logic v, input logic [7:0] d, input logic s);
        in_valid = v; in_data = d; start = s;
        @(posedge clk);
        model_edge(v, d, s);
        @(negedge clk);
        compare_outputs();
    endtask

    task automatic clear_log();
        we_pulses = 0;
        wr_addr_q.delete();
        wr_data_q.delete();
    endtask

    // Streams one frame; start_at inserts an extra start pulse before that byte position.
    task automatic send_frame(input int n, input logic [31:0] words[$], input bit gaps,
                              input bit bad_csum, input int start_at);
        logic [7:0] q[$];
        logic [7:0] x;
        int g;
        q.push_back(8'(n >> 8));
        q.push_back(8'(n));
        foreach (words[i]) begin
            q.push_back(words[i][31:24]);
            q.push_back(words[i][23:16]);
            q.push_back(words[i][15:8]);
            q.push_back(words[i][7:0]);
        end
`ifdef LOADER_CHECKSUM_EN
        if (n <= int'(MAXW)) begin
            x = 8'h00;
            foreach (q[i]) x ^= q[i];
            if (bad_csum) x ^= 8'h5A;
            q.push_back(x);
        end
`endif
        step(1'b0, 8'($urandom), 1'b1);
        foreach (q[i]) begin
            g = gaps ? int'($urandom_range(3)) : 0;
            for (int j = 0; j < g; j++) step(1'b0, 8'($urandom), 1'($urandom_range(1)));
            if (i == start_at) step(1'b0, 8'($urandom), 1'b1);
            step(1'b1, q[i], 1'b0);
        end
        repeat (3) step(1'b0, 8'h00, 1'b0);
    endtask

    task automatic do_reset();
        in_valid = 0; start = 0; in_data = 0;
        rst_n = 1'b0;
        model_reset();
        #1;
        compare_outputs();
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_cpu_hold", 32'(cpu_hold), 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        logic [31:0] w[$];
        int n;
        model_reset();
        repeat (2) @(negedge clk);
        do_reset();

        // Single word frame
        clear_log();
        w = '{32'hE000_0000};
        send_frame(1, w, 1'b0, 1'b0, -1);
        chk("t1_pulses", 32'(we_pulses), 32'd1);
        chk("t1_addr", wr_addr_q[0], 32'h0);
        chk("t1_data", wr_data_q[0], 32'hE000_0000);
        chk("t1_done", 32'(done), 32'd1);
        chk("t1_hold", 32'(cpu_hold), 32'd0);

        // Two words with valid gaps
        clear_log();
        w = '{32'hE3A0_0014, 32'hE3A0_1A01};
        send_frame(2, w, 1'b1, 1'b0, -1);
        chk("t2_pulses", 32'(we_pulses), 32'd2);
        chk("t2_addr0", wr_addr_q[0], 32'h0);
        chk("t2_data0", wr_data_q[0], 32'hE3A0_0014);
        chk("t2_addr1", wr_addr_q[1], 32'h4);
        chk("t2_data1", wr_data_q[1], 32'hE3A0_1A01);

        // Oversize length
        clear_log();
        w = {};
        send_frame(int'(MAXW) + 1, w, 1'b0, 1'b0, -1);
        chk("t3_pulses", 32'(we_pulses), 32'd0);
        chk("t3_error", 32'(error), 32'd1);
        chk("t3_ready", 32'(in_ready), 32'd0);

`ifdef LOADER_CHECKSUM_EN
        // Wrong checksum after a written word
        clear_log();
        w = '{32'h0102_0304};
        send_frame(1, w, 1'b0, 1'b1, -1);
        chk("t4_pulses", 32'(we_pulses), 32'd1);
        chk("t4_csum_model", 32'(m_csum), 32'h05);
        chk("t4_error", 32'(error), 32'd1);
        chk("t4_done", 32'(done), 32'd0);
`endif

        // Reset mid-DATA, then a fresh frame
        step(1'b0, 8'h00, 1'b1);
        step(1'b1, 8'h00, 1'b0);
        step(1'b1, 8'h01, 1'b0);
        step(1'b1, 8'hAA, 1'b0);
        step(1'b1, 8'hBB, 1'b0);
        do_reset();
        chk("t5_done", 32'(done), 32'd0);
        clear_log();
        w = '{32'h1122_3344};
        send_frame(1, w, 1'b0, 1'b0, -1);
        chk("t5_pulses", 32'(we_pulses), 32'd1);
        chk("t5_addr", wr_addr_q[0], 32'h0);
        chk("t5_data", wr_data_q[0], 32'h1122_3344);

        // Empty frame, then a start pulse during LEN_LO
        clear_log();
        w = {};
        send_frame(0, w, 1'b0, 1'b0, -1);
        chk("t6_pulses", 32'(we_pulses), 32'd0);
        chk("t6_done", 32'(done), 32'd1);
        clear_log();
        w = '{32'hCAFE_F00D};
        send_frame(1, w, 1'b0, 1'b0, 1);
        chk("t6b_pulses", 32'(we_pulses), 32'd1);
        chk("t6b_data", wr_data_q[0], 32'hCAFE_F00D);
        chk("t6b_done", 32'(done), 32'd1);

        // Random frames
        for (int f = 0; f < 25; f++) begin
            clear_log();
            w = {};
            n = ($urandom_range(9) == 0) ? int'(MAXW) + 1 + int'($urandom_range(50))
                                         : int'($urandom_range(6));
            if (n <= int'(MAXW)) for (int i = 0; i < n; i++) w.push_back($urandom);
            send_frame(n, w, 1'($urandom_range(1)), ($urandom_range(3) == 0), -1);
            chk("rand_pulses", 32'(we_pulses), (n <= int'(MAXW)) ? 32'(n) : 32'd0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
